apb_req_arbiter: RTL



---
 rtl/apb_req_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master request port between NUM_REQ requesters.
// Define APB_ARB_RETRY_EN to retry once on PSLVERR and expose the 'retried' pulse.
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned XFER_CYCLES = 3
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      slverr,
`ifdef APB_ARB_RETRY_EN
    output logic                      retried,
`endif
    output logic                      transfer,
    output logic                      READ_WRITE,
    output logic [ADDR_W-1:0]         apb_write_paddr,
    output logic [ADDR_W-1:0]         apb_read_paddr,
    output logic [DATA_W-1:0]         apb_write_data,
    input  logic [DATA_W-1:0]         apb_read_data_out,
    input  logic                      PSLVERR
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(XFER_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE, RETRY} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]  r_win, w_win_nxt;
    logic              r_rw, w_rw_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

    logic [NUM_REQ-1:0] w_gnt_nxt, w_done_nxt, w_win_onehot, w_sel_onehot;
    logic [DATA_W-1:0]  w_rdata_nxt, w_wdo_nxt;
    logic [ADDR_W-1:0]  w_wpaddr_nxt, w_rpaddr_nxt;
    logic               w_slverr_nxt, w_transfer_nxt, w_read_write_nxt;
    logic               w_load, w_clear;

    logic               w_any;
    logic [IDX_W-1:0]   w_sel, w_cand;
    logic               w_end;
    logic               w_do_retry;
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

`ifdef APB_ARB_RETRY_EN
    logic r_retry_used, w_retry_used_nxt, w_retried_nxt;
    assign w_do_retry = PSLVERR & ~r_retry_used;
`else
    assign w_do_retry = 1'b0;
`endif

    assign w_end        = (r_cnt == CNT_W'(XFER_CYCLES));
    assign w_win_onehot = NUM_REQ'(1) << r_win;
    assign w_sel_onehot = NUM_REQ'(1) << w_sel;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // First set request strictly after the last winner, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (req[w_cand] && !w_any) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_rr_ptr        <= IDX_W'(NUM_REQ - 1);
            r_win           <= '0;
            r_rw            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            gnt             <= '0;
            done            <= '0;
            rdata           <= '0;
            slverr          <= 1'b0;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_write_paddr <= '0;
            apb_read_paddr  <= '0;
            apb_write_data  <= '0;
`ifdef APB_ARB_RETRY_EN
            r_retry_used    <= 1'b0;
            retried         <= 1'b0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_win           <= w_win_nxt;
            r_rw            <= w_rw_nxt;
            r_addr          <= w_addr_nxt;
            r_wdata         <= w_wdata_nxt;
            gnt             <= w_gnt_nxt;
            done            <= w_done_nxt;
            rdata           <= w_rdata_nxt;
            slverr          <= w_slverr_nxt;
            transfer        <= w_transfer_nxt;
            READ_WRITE      <= w_read_write_nxt;
            apb_write_paddr <= w_wpaddr_nxt;
            apb_read_paddr  <= w_rpaddr_nxt;
            apb_write_data  <= w_wdo_nxt;
`ifdef APB_ARB_RETRY_EN
            r_retry_used    <= w_retry_used_nxt;
            retried         <= w_retried_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = XFER;
            XFER:    if (w_end) w_state_nxt = w_do_retry ? RETRY : DONE;
            RETRY:   w_state_nxt = XFER;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_win_nxt        = r_win;
        w_rw_nxt         = r_rw;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_gnt_nxt        = gnt;
        w_done_nxt       = '0;
        w_rdata_nxt      = rdata;
        w_slverr_nxt     = slverr;
        w_transfer_nxt   = transfer;
        w_read_write_nxt = READ_WRITE;
        w_wpaddr_nxt     = apb_write_paddr;
        w_rpaddr_nxt     = apb_read_paddr;
        w_wdo_nxt        = apb_write_data;
        w_load           = 1'b0;
        w_clear          = 1'b0;
`ifdef APB_ARB_RETRY_EN
        w_retry_used_nxt = r_retry_used;
        w_retried_nxt    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_nxt      = w_sel_onehot;
                    w_win_nxt      = w_sel;
                    w_rw_nxt       = req_rw[w_sel];
                    w_addr_nxt     = w_addr_arr[w_sel];
                    w_wdata_nxt    = w_wdata_arr[w_sel];
                    w_transfer_nxt = 1'b1;
                    w_cnt_nxt      = CNT_W'(1);
                    w_load         = 1'b1;
`ifdef APB_ARB_RETRY_EN
                    w_retry_used_nxt = 1'b0;
`endif
                end
            end
            XFER: begin
                if (w_end) begin
                    w_cnt_nxt      = '0;
                    w_transfer_nxt = 1'b0;
                    w_clear        = 1'b1;
                    if (!w_do_retry) begin
                        w_done_nxt   = w_win_onehot;
                        w_rdata_nxt  = r_rw ? '0 : apb_read_data_out;
                        w_slverr_nxt = PSLVERR;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RETRY: begin
                w_transfer_nxt = 1'b1;
                w_cnt_nxt      = CNT_W'(1);
                w_load         = 1'b1;
`ifdef APB_ARB_RETRY_EN
                w_retried_nxt    = 1'b1;
                w_retry_used_nxt = 1'b1;
`endif
            end
            DONE: begin
                w_gnt_nxt    = '0;
                w_rr_ptr_nxt = r_win;
            end
            default: ;
        endcase

        // Drive values come from the (possibly just latched) command; the
        // unused direction's bus is held at zero.
        if (w_load) begin
            w_read_write_nxt = w_rw_nxt;
            w_wpaddr_nxt     = w_rw_nxt ? w_addr_nxt : '0;
            w_rpaddr_nxt     = w_rw_nxt ? '0 : w_addr_nxt;
            w_wdo_nxt        = w_rw_nxt ? w_wdata_nxt : '0;
        end else if (w_clear) begin
            w_read_write_nxt = 1'b0;
            w_wpaddr_nxt     = '0;
            w_rpaddr_nxt     = '0;
            w_wdo_nxt        = '0;
        end
    end

endmodule
